// File: rtl/lv_lbist_seq_if.sv
// Request/acknowledge test bus between the LBIST sequencer and the channels.
// The sequencer raises a one-hot request; the addressed channel answers with a
// one-cycle acknowledge and an error flag that is valid alongside it.
interface lv_lbist_seq_if #(
  parameter int CH_NUM = 2
);
  logic [CH_NUM-1:0] o_req;
  logic [CH_NUM-1:0] i_ack;
  logic [CH_NUM-1:0] i_err;

  modport master (output o_req, input i_ack, input i_err);
  modport slave  (input o_req, output i_ack, output i_err);
endinterface

// File: rtl/lv_lbist_seq.sv
// Logic-BIST run sequencer: walks through the channels, issues REQ_NUM requests
// per channel, counts good acknowledges, grades each channel, watches the
// interrupt lines and bounds the whole run with a global timeout.
module lv_lbist_seq #(
  parameter int CH_NUM   = 2,
  parameter int REQ_NUM  = 4,
  parameter int OK_TH    = 3,
  parameter int REQ_TMO  = 64,
  parameter int GLB_TMO  = 96000,
  parameter int INTB_NUM = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_bist_en,
  lv_lbist_seq_if.master      bus,
  input  logic [INTB_NUM-1:0] i_intb_pulse,
  output logic [CH_NUM-1:0]   o_ch_pass,
  output logic                o_intb_pass,
  output logic                o_tmo_err,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_all_pass
);

  localparam int CH_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int CNT_W = $clog2(REQ_NUM + 1);
  localparam int WT_W  = $clog2(REQ_TMO + 1);
  localparam int GLB_W = $clog2(GLB_TMO + 1);

  localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(CH_NUM - 1);
  localparam logic [CNT_W-1:0]  REQ_LIM  = CNT_W'(REQ_NUM);
  localparam logic [CNT_W-1:0]  OK_LIM   = CNT_W'(OK_TH);
  localparam logic [WT_W-1:0]   WAIT_MAX = WT_W'(REQ_TMO - 1);
  localparam logic [GLB_W-1:0]  GLB_MAX  = GLB_W'(GLB_TMO - 1);
  localparam logic [CH_NUM-1:0] CH_ONE   = CH_NUM'(1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_GAP  = 3'd2,
    ST_EVAL = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t             state_r;
  logic [CH_W-1:0]    ch_r;
  logic [CNT_W-1:0]   issued_r;
  logic [CNT_W-1:0]   good_r;
  logic [WT_W-1:0]    wait_r;
  logic [GLB_W-1:0]   glb_r;

  logic [CH_NUM-1:0]  ch_sel_s;
  logic [CH_NUM-1:0]  ch_pass_eval_s;
  logic               ack_s;
  logic               err_s;
  logic               run_s;
  logic               glb_hit_s;
  logic               intb_hit_s;
  logic               eval_pass_s;

  // Decode the active channel and the run-wide conditions used by the FSM.
  always_comb begin
    ch_sel_s    = CH_ONE << ch_r;
    ack_s       = |(bus.i_ack & ch_sel_s);
    err_s       = |(bus.i_err & ch_sel_s);
    run_s       = (state_r == ST_REQ) || (state_r == ST_GAP) || (state_r == ST_EVAL);
    glb_hit_s   = run_s && (glb_r == GLB_MAX);
    intb_hit_s  = |i_intb_pulse;
    eval_pass_s = (good_r >= OK_LIM);
    if (eval_pass_s) begin
      ch_pass_eval_s = o_ch_pass | ch_sel_s;
    end else begin
      ch_pass_eval_s = o_ch_pass;
    end
  end

  // Run sequencer FSM with all outputs registered; reset beats enable, enable beats everything else.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r     <= ST_IDLE;
      ch_r        <= '0;
      issued_r    <= '0;
      good_r      <= '0;
      wait_r      <= '0;
      glb_r       <= '0;
      bus.o_req   <= '0;
      o_ch_pass   <= '0;
      o_intb_pass <= 1'b1;
      o_tmo_err   <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_all_pass  <= 1'b0;
    end else if (!i_bist_en) begin
      // Abort or clear: results stay readable, activity stops.
      state_r    <= ST_IDLE;
      bus.o_req  <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_all_pass <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r     <= ST_REQ;
          ch_r        <= '0;
          issued_r    <= '0;
          good_r      <= '0;
          wait_r      <= '0;
          glb_r       <= '0;
          bus.o_req   <= CH_ONE;
          o_ch_pass   <= '0;
          o_intb_pass <= 1'b1;
          o_tmo_err   <= 1'b0;
          o_busy      <= 1'b1;
          o_done      <= 1'b0;
          o_all_pass  <= 1'b0;
        end
        ST_REQ, ST_GAP, ST_EVAL: begin
          if (intb_hit_s) begin
            o_intb_pass <= 1'b0;
          end
          if (glb_hit_s) begin
            // Whole-run limit reached: unevaluated channels keep their cleared pass bit.
            state_r    <= ST_DONE;
            bus.o_req  <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b1;
            o_tmo_err  <= 1'b1;
            o_all_pass <= 1'b0;
          end else begin
            glb_r <= glb_r + 1'b1;
            case (state_r)
              ST_REQ: begin
                // An acknowledge on the last waiting cycle still counts.
                if (ack_s || (wait_r == WAIT_MAX)) begin
                  state_r   <= ST_GAP;
                  bus.o_req <= '0;
                  if (issued_r != REQ_LIM) begin
                    issued_r <= issued_r + 1'b1;
                  end
                  if (ack_s && !err_s && (good_r != REQ_LIM)) begin
                    good_r <= good_r + 1'b1;
                  end
                end else begin
                  wait_r <= wait_r + 1'b1;
                end
              end
              ST_GAP: begin
                if (issued_r < REQ_LIM) begin
                  state_r   <= ST_REQ;
                  bus.o_req <= ch_sel_s;
                  wait_r    <= '0;
                end else begin
                  state_r <= ST_EVAL;
                end
              end
              ST_EVAL: begin
                o_ch_pass <= ch_pass_eval_s;
                issued_r  <= '0;
                good_r    <= '0;
                if (ch_r == CH_LAST) begin
                  state_r    <= ST_DONE;
                  o_busy     <= 1'b0;
                  o_done     <= 1'b1;
                  o_all_pass <= (&ch_pass_eval_s) & o_intb_pass & ~intb_hit_s;
                end else begin
                  state_r   <= ST_REQ;
                  ch_r      <= ch_r + 1'b1;
                  bus.o_req <= ch_sel_s << 1;
                  wait_r    <= '0;
                end
              end
              default: begin
                state_r <= ST_IDLE;
              end
            endcase
          end
        end
        ST_DONE: begin
          state_r <= ST_DONE;
          o_done  <= 1'b1;
        end
        default: begin
          state_r    <= ST_IDLE;
          bus.o_req  <= '0;
          o_busy     <= 1'b0;
          o_done     <= 1'b0;
          o_all_pass <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lv_lbist_seq.sv
// Directed bench for lv_lbist_seq: instance 0 uses default parameters,
// instance 1 uses a short global timeout. A channel responder model answers
// requests after a programmable delay with a programmable error pattern.
module tb_lv_lbist_seq;

  logic clk = 1'b0;
  logic i_rst;
  logic bist_en_a [2];
  logic [1:0] intb_a [2];
  logic [1:0] ch_pass_a [2];
  logic intbp_a [2];
  logic tmo_a [2];
  logic busy_a [2];
  logic done_a [2];
  logic allp_a [2];
  logic [1:0] req_a [2];
  logic [1:0] ack_a [2];
  logic [1:0] err_a [2];

  int dly [2][2];
  logic [3:0] epat [2][2];
  int cnt [2][2];
  int idx [2][2];

  int checks = 0;
  int errors = 0;
  int n, m;

  always #5 clk = ~clk;

  lv_lbist_seq_if #(.CH_NUM(2)) bus0 ();
  lv_lbist_seq_if #(.CH_NUM(2)) bus1 ();

  assign req_a[0]   = bus0.o_req;
  assign req_a[1]   = bus1.o_req;
  assign bus0.i_ack = ack_a[0];
  assign bus0.i_err = err_a[0];
  assign bus1.i_ack = ack_a[1];
  assign bus1.i_err = err_a[1];

  lv_lbist_seq dut0 (
    .i_clk(clk), .i_rst(i_rst), .i_bist_en(bist_en_a[0]), .bus(bus0),
    .i_intb_pulse(intb_a[0]), .o_ch_pass(ch_pass_a[0]), .o_intb_pass(intbp_a[0]),
    .o_tmo_err(tmo_a[0]), .o_busy(busy_a[0]), .o_done(done_a[0]), .o_all_pass(allp_a[0])
  );

  lv_lbist_seq #(.GLB_TMO(100)) dut1 (
    .i_clk(clk), .i_rst(i_rst), .i_bist_en(bist_en_a[1]), .bus(bus1),
    .i_intb_pulse(intb_a[1]), .o_ch_pass(ch_pass_a[1]), .o_intb_pass(intbp_a[1]),
    .o_tmo_err(tmo_a[1]), .o_busy(busy_a[1]), .o_done(done_a[1]), .o_all_pass(allp_a[1])
  );

  // Channel responder: acknowledge dly cycles after a request rises (0 = never).
  initial begin
    ack_a[0] = 2'b00; ack_a[1] = 2'b00;
    err_a[0] = 2'b00; err_a[1] = 2'b00;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < 2; c++) begin
          if (busy_a[d] !== 1'b1) idx[d][c] = 0;
          if (req_a[d][c] === 1'b1) begin
            cnt[d][c] = cnt[d][c] + 1;
            if (cnt[d][c] == dly[d][c]) begin
              ack_a[d][c] = 1'b1;
              err_a[d][c] = epat[d][c][idx[d][c] % 4];
              idx[d][c] = idx[d][c] + 1;
            end else begin
              ack_a[d][c] = 1'b0;
              err_a[d][c] = 1'b0;
            end
          end else begin
            cnt[d][c] = 0;
            ack_a[d][c] = 1'b0;
            err_a[d][c] = 1'b0;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_run(input int d);
    @(negedge clk);
    bist_en_a[d] = 1'b1;
    @(posedge clk);
    #1;
    chk("req_first", {30'd0, req_a[d]}, 32'd1);
    chk("busy_start", {31'd0, busy_a[d]}, 32'd1);
  endtask

  task automatic wait_done(input int d, input int max, output int cyc);
    cyc = 0;
    while (done_a[d] !== 1'b1 && cyc < max) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic stop_run(input int d);
    @(negedge clk);
    bist_en_a[d] = 1'b0;
    @(posedge clk);
    #1;
    chk("stop_done", {31'd0, done_a[d]}, 32'd0);
    chk("stop_busy", {31'd0, busy_a[d]}, 32'd0);
    chk("stop_allp", {31'd0, allp_a[d]}, 32'd0);
    chk("stop_req", {30'd0, req_a[d]}, 32'd0);
  endtask

  initial begin
    i_rst = 1'b1;
    bist_en_a[0] = 1'b0; bist_en_a[1] = 1'b0;
    intb_a[0] = 2'b00; intb_a[1] = 2'b00;
    dly[0][0] = 3; dly[0][1] = 3; dly[1][0] = 60; dly[1][1] = 3;
    epat[0][0] = 4'b0000; epat[0][1] = 4'b0000; epat[1][0] = 4'b0000; epat[1][1] = 4'b0000;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", {30'd0, req_a[0]}, 32'd0);
    chk("rst_ch_pass", {30'd0, ch_pass_a[0]}, 32'd0);
    chk("rst_intb_pass", {31'd0, intbp_a[0]}, 32'd1);
    chk("rst_tmo", {31'd0, tmo_a[0]}, 32'd0);
    chk("rst_busy", {31'd0, busy_a[0]}, 32'd0);
    chk("rst_done", {31'd0, done_a[0]}, 32'd0);
    chk("rst_allp", {31'd0, allp_a[0]}, 32'd0);
    @(negedge clk);
    i_rst = 1'b0;

    // All good, ack after 3 cycles: 2 channels x (4 x 4 + 1) cycles
    start_run(0);
    wait_done(0, 2000, n);
    chk("good_cycles", n, 32'd34);
    chk("good_ch_pass", {30'd0, ch_pass_a[0]}, 32'd3);
    chk("good_allp", {31'd0, allp_a[0]}, 32'd1);
    chk("good_tmo", {31'd0, tmo_a[0]}, 32'd0);
    chk("good_busy", {31'd0, busy_a[0]}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("done_hold", {31'd0, done_a[0]}, 32'd1);
    stop_run(0);
    chk("hold_ch_pass", {30'd0, ch_pass_a[0]}, 32'd3);

    // Ch0 reports errors on 2 of 4 acks
    epat[0][0] = 4'b0101;
    start_run(0);
    wait_done(0, 2000, n);
    chk("err_cycles", n, 32'd34);
    chk("err_ch_pass", {30'd0, ch_pass_a[0]}, 32'd2);
    chk("err_allp", {31'd0, allp_a[0]}, 32'd0);
    chk("err_done", {31'd0, done_a[0]}, 32'd1);
    stop_run(0);
    epat[0][0] = 4'b0000;

    // Ch1 never acks: each request lasts 64 cycles
    dly[0][1] = 0;
    start_run(0);
    n = 0;
    while (req_a[0] !== 2'b10 && n < 200) begin @(posedge clk); #1; n++; end
    chk("noack_ch1_start", n, 32'd17);
    m = 0;
    while (req_a[0][1] === 1'b1 && m < 200) begin @(posedge clk); #1; m++; end
    chk("noack_req_len", m, 32'd64);
    wait_done(0, 2000, n);
    chk("noack_tail", n, 32'd197);
    chk("noack_ch_pass", {30'd0, ch_pass_a[0]}, 32'd1);
    chk("noack_tmo", {31'd0, tmo_a[0]}, 32'd0);
    chk("noack_done", {31'd0, done_a[0]}, 32'd1);
    stop_run(0);

    // Ack on the last waiting cycle beats the request timeout
    dly[0][0] = 64; dly[0][1] = 3;
    start_run(0);
    wait_done(0, 2000, n);
    chk("edge_cycles", n, 32'd278);
    chk("edge_ch_pass", {30'd0, ch_pass_a[0]}, 32'd3);
    stop_run(0);
    dly[0][0] = 3;

    // Global timeout at count 99 with GLB_TMO=100
    start_run(1);
    wait_done(1, 500, n);
    chk("glb_cycles", n, 32'd100);
    chk("glb_tmo", {31'd0, tmo_a[1]}, 32'd1);
    chk("glb_ch_pass", {30'd0, ch_pass_a[1]}, 32'd0);
    chk("glb_allp", {31'd0, allp_a[1]}, 32'd0);
    chk("glb_busy", {31'd0, busy_a[1]}, 32'd0);
    stop_run(1);
    chk("glb_tmo_hold", {31'd0, tmo_a[1]}, 32'd1);

    // Interrupt pulse mid-run is sticky until the next run
    start_run(0);
    repeat (10) @(negedge clk);
    intb_a[0] = 2'b10;
    @(negedge clk);
    intb_a[0] = 2'b00;
    wait_done(0, 2000, n);
    chk("intb_pass", {31'd0, intbp_a[0]}, 32'd0);
    chk("intb_ch_pass", {30'd0, ch_pass_a[0]}, 32'd3);
    chk("intb_allp", {31'd0, allp_a[0]}, 32'd0);
    stop_run(0);
    chk("intb_hold", {31'd0, intbp_a[0]}, 32'd0);
    start_run(0);
    chk("intb_restore", {31'd0, intbp_a[0]}, 32'd1);
    chk("restart_clear", {30'd0, ch_pass_a[0]}, 32'd0);
    wait_done(0, 2000, n);
    chk("intb_rerun_allp", {31'd0, allp_a[0]}, 32'd1);
    stop_run(0);

    // Enable drop mid-request on ch0, then restart with cleared counts
    start_run(0);
    repeat (10) @(posedge clk);
    #1;
    stop_run(0);
    start_run(0);
    wait_done(0, 2000, n);
    chk("abort_restart_cycles", n, 32'd34);
    chk("abort_restart_pass", {30'd0, ch_pass_a[0]}, 32'd3);
    stop_run(0);

    // Reset mid-run with enable still high
    start_run(0);
    repeat (20) @(posedge clk);
    #1;
    chk("pre_rst_pass", {30'd0, ch_pass_a[0]}, 32'd1);
    @(negedge clk);
    i_rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_req", {30'd0, req_a[0]}, 32'd0);
    chk("mrst_busy", {31'd0, busy_a[0]}, 32'd0);
    chk("mrst_ch_pass", {30'd0, ch_pass_a[0]}, 32'd0);
    chk("mrst_intb", {31'd0, intbp_a[0]}, 32'd1);
    @(negedge clk);
    i_rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mrst_restart_req", {30'd0, req_a[0]}, 32'd1);
    wait_done(0, 2000, n);
    chk("mrst_cycles", n, 32'd34);
    chk("mrst_pass", {30'd0, ch_pass_a[0]}, 32'd3);
    stop_run(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
